multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port run, input, 1, level enable; 0 parks the sequencer in IDLE at the next instruction boundary.
REQ-004 SHALL have port op, input, 4, opcode field of the instruction register (0000 jal ... 1111 ori, standard 16-op map).
REQ-005 SHALL have port zero, input, 1, ALU compare result (beq: equal; ble: less-or-equal).
REQ-006 SHALL have ports imem_ready and dmem_ready, input, 1 each, memory transfer-complete strobes.
REQ-007 SHALL have ports imem_req and dmem_req, output, 1 each, memory request levels.
REQ-008 SHALL have ports ir_we and pc_we, output, 1 each, single-cycle load strobes for IR and PC.
REQ-009 SHALL have datapath control outputs: PCsrc (2: 00 PC+2, 01 PC+imm, 10 rs1+imm), m2reg (1), wmem (1), memc (1: 0 byte, 1 word), ALUOp (3: 0 add, 1 sub, 2 and, 3 or, 4 beq, 5 ble), alucsrc (1: 0 reg, 1 imm), wreg (1), jal (1).
REQ-010 SHALL have port state, output, 3, current state code: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5.
REQ-011 SHALL have port retired, output, 16, count of completed instructions.

Function
REQ-012 SHALL be a Moore FSM with control outputs decoded from state and the op latched in IR; outputs not listed for a state SHALL be 0.
REQ-013 IDLE: stay while run=0; go to FETCH when run=1.
REQ-014 FETCH: imem_req=1; stay until imem_ready=1; on that cycle ir_we=1 and next state DECODE.
REQ-015 DECODE: one cycle, no strobes; next EXEC.
REQ-016 EXEC, ALU ops 1000-1111: ALUOp=op[1:0], alucsrc=op[2]; next WB.
REQ-017 EXEC, beq/ble: ALUOp 4/5; pc_we=1, PCsrc=01 if zero=1 else 00; instruction retires; next FETCH or IDLE.
REQ-018 EXEC, jal/jalr: wreg=1, jal=1, pc_we=1, PCsrc 01 (jal) or 10 (jalr); retires; next FETCH or IDLE.
REQ-019 EXEC, loads/stores 0100-0111: ALUOp=0, alucsrc=1 (address calc); next MEM.
REQ-020 MEM: dmem_req=1, ALUOp=0, alucsrc=1 held stable, memc=op[0], wmem=op[1]; stay until dmem_ready=1.
REQ-021 On dmem_ready in MEM: loads go to WB; stores assert pc_we=1 with PCsrc=00, retire, and go to FETCH/IDLE.
REQ-022 WB: wreg=1; loads m2reg=1, memc=op[0]; ALU ops keep EXEC ALUOp/alucsrc, m2reg=0; pc_we=1, PCsrc=00; retire; next FETCH/IDLE.
REQ-023 pc_we SHALL pulse exactly once per instruction, in its final state only, so PC is stable for link and branch calculation.
REQ-024 At each retire cycle, next state SHALL be FETCH if run=1, else IDLE; run=0 SHALL NOT abort an instruction in progress.
REQ-025 retired SHALL increment by 1 on each retire cycle, wrapping 0xFFFF->0x0000.
REQ-026 wmem and dmem_req SHALL never be 1 outside MEM; wreg never 1 in FETCH/DECODE/MEM.
REQ-027 Latency without wait states: branch/jump 3 cycles, ALU 4, store 4, load 5; each wait cycle adds 1.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, retired=0, and all strobes/control outputs to 0, including mid-instruction and mid-memory-wait.
REQ-029 After rst_n deasserts, first transition SHALL occur on the first rising clk edge with run=1.

Verification
REQ-030 Reset, run=1, op=1000, ready strobes immediate -> states 1,2,3,5,1; WB: wreg=1, ALUOp=0, alucsrc=0, pc_we=1; retired=1.
REQ-031 op=0010 with zero=1, then zero=0 -> EXEC pc_we=1 with PCsrc=01, then 00; neither writes reg; retired +1 each.
REQ-032 op=0101, dmem_ready low 3 cycles -> MEM held 4 cycles with dmem_req=1, memc=1, wmem=0; WB m2reg=1, wreg=1; total 8 cycles.
REQ-033 op=0110 -> MEM wmem=1, memc=0; no WB state; pc_we only on dmem_ready cycle.
REQ-034 run dropped during EXEC of op=1100 -> instruction completes through WB, then state=0 and stays; retired +1.
REQ-035 rst_n pulsed low in MEM with retired=0xFFFF preloaded via 65535 retires -> outputs 0 asynchronously; separately, 65536th retire wraps retired to 0x0000.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath/memories (slave).
interface multicycle_control_if;
   logic        run;
   logic [3:0]  op;
   logic        zero;
   logic        imem_ready;
   logic        dmem_ready;
   logic        imem_req;
   logic        dmem_req;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  PCsrc;
   logic        m2reg;
   logic        wmem;
   logic        memc;
   logic [2:0]  ALUOp;
   logic        alucsrc;
   logic        wreg;
   logic        jal;
   logic [2:0]  state;
   logic [15:0] retired;

   modport master (
      input  run, op, zero, imem_ready, dmem_ready,
      output imem_req, dmem_req, ir_we, pc_we, PCsrc, m2reg, wmem, memc,
             ALUOp, alucsrc, wreg, jal, state, retired
   );

   modport slave (
      output run, op, zero, imem_ready, dmem_ready,
      input  imem_req, dmem_req, ir_we, pc_we, PCsrc, m2reg, wmem, memc,
             ALUOp, alucsrc, wreg, jal, state, retired
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with datapath
// controls decoded from the current state and the opcode held in IR.
module multicycle_control (
   input logic                  clk,
   input logic                  rst_n,
   multicycle_control_if.master bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } state_t;

   state_t      cur;
   state_t      nxt;
   logic [15:0] retired_q;
   logic        retire;

   logic        is_alu;
   logic        is_mem;
   logic        is_store;
   logic        is_branch;

   logic        imem_req;
   logic        dmem_req;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  PCsrc;
   logic        m2reg;
   logic        wmem;
   logic        memc;
   logic [2:0]  ALUOp;
   logic        alucsrc;
   logic        wreg;
   logic        jal;

   assign is_alu    = bus.op[3];
   assign is_mem    = (bus.op[3:2] == 2'b01);
   assign is_store  = is_mem && bus.op[1];
   assign is_branch = (bus.op[3:1] == 3'b001);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= IDLE;
         retired_q <= '0;
      end else begin
         cur <= nxt;
         if (retire) retired_q <= retired_q + 16'd1;
      end
   end

   always_comb begin
      nxt      = cur;
      retire   = 1'b0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      PCsrc    = 2'b00;
      m2reg    = 1'b0;
      wmem     = 1'b0;
      memc     = 1'b0;
      ALUOp    = 3'd0;
      alucsrc  = 1'b0;
      wreg     = 1'b0;
      jal      = 1'b0;

      case (cur)
         IDLE: begin
            if (bus.run) nxt = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ready) begin
               ir_we = 1'b1;
               nxt   = DECODE;
            end
         end
         DECODE: begin
            nxt = EXEC;
         end
         EXEC: begin
            if (is_alu) begin
               ALUOp   = {1'b0, bus.op[1:0]};
               alucsrc = bus.op[2];
               nxt     = WB;
            end else if (is_mem) begin
               alucsrc = 1'b1;
               nxt     = MEM;
            end else if (is_branch) begin
               ALUOp  = bus.op[0] ? 3'd5 : 3'd4;
               pc_we  = 1'b1;
               PCsrc  = bus.zero ? 2'b01 : 2'b00;
               retire = 1'b1;
            end else begin
               // jal/jalr: link write and PC update share the same final cycle
               wreg   = 1'b1;
               jal    = 1'b1;
               pc_we  = 1'b1;
               PCsrc  = bus.op[0] ? 2'b10 : 2'b01;
               retire = 1'b1;
            end
         end
         MEM: begin
            dmem_req = 1'b1;
            alucsrc  = 1'b1;
            memc     = bus.op[0];
            wmem     = bus.op[1];
            if (bus.dmem_ready) begin
               if (is_store) begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
               end else begin
                  nxt = WB;
               end
            end
         end
         WB: begin
            wreg   = 1'b1;
            pc_we  = 1'b1;
            retire = 1'b1;
            if (is_alu) begin
               ALUOp   = {1'b0, bus.op[1:0]};
               alucsrc = bus.op[2];
            end else begin
               m2reg = 1'b1;
               memc  = bus.op[0];
            end
         end
         default: begin
            nxt = IDLE;
         end
      endcase

      // run is only consulted at instruction boundaries
      if (retire) nxt = bus.run ? FETCH : IDLE;
   end

   assign bus.imem_req = imem_req;
   assign bus.dmem_req = dmem_req;
   assign bus.ir_we    = ir_we;
   assign bus.pc_we    = pc_we;
   assign bus.PCsrc    = PCsrc;
   assign bus.m2reg    = m2reg;
   assign bus.wmem     = wmem;
   assign bus.memc     = memc;
   assign bus.ALUOp    = ALUOp;
   assign bus.alucsrc  = alucsrc;
   assign bus.wreg     = wreg;
   assign bus.jal      = jal;
   assign bus.state    = cur;
   assign bus.retired  = retired_q;

   a_mem_confined: assert property (@(posedge clk) disable iff (!rst_n)
      (wmem || dmem_req) |-> (cur == MEM));

   a_wreg_window: assert property (@(posedge clk) disable iff (!rst_n)
      wreg |-> !(cur inside {FETCH, DECODE, MEM}));

endmodule

// File: tb/tb_multicycle_control.sv
// Directed plus randomized bench for multicycle_control against a per-instruction
// phase-list reference model.
module tb_multicycle_control;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;

   logic        clk;
   logic        rst_n;
   int          checks;
   int          failures;
   logic [15:0] exp_retired;
   int unsigned n_bulk;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [17:0] observed();
      return {bus.state, bus.imem_req, bus.dmem_req, bus.ir_we, bus.pc_we, bus.PCsrc,
              bus.m2reg, bus.wmem, bus.memc, bus.ALUOp, bus.alucsrc, bus.wreg, bus.jal};
   endfunction

   // Expected controls for one cycle, given its phase and whether it ends the instruction
   function automatic logic [17:0] model(input logic [2:0] st, input logic [3:0] o,
                                         input logic z, input logic rdy, input logic last);
      logic       ireq, dreq, irwe, pcwe, m2r, wm, mc, acs, wr, jl;
      logic [1:0] psrc;
      logic [2:0] aop;
      logic       alu_op, mem_op, br_op;
      {ireq, dreq, irwe, pcwe, m2r, wm, mc, acs, wr, jl} = '0;
      psrc   = 2'b00;
      aop    = 3'd0;
      alu_op = o[3];
      mem_op = (o[3:2] == 2'b01);
      br_op  = (o[3:1] == 3'b001);
      case (st)
         S_FETCH: begin
            ireq = 1'b1;
            irwe = rdy;
         end
         S_EXEC: begin
            if (alu_op) begin
               aop = {1'b0, o[1:0]};
               acs = o[2];
            end else if (mem_op) begin
               acs = 1'b1;
            end else if (br_op) begin
               aop = o[0] ? 3'd5 : 3'd4;
            end else begin
               wr = 1'b1;
               jl = 1'b1;
            end
         end
         S_MEM: begin
            dreq = 1'b1;
            acs  = 1'b1;
            mc   = o[0];
            wm   = o[1];
         end
         S_WB: begin
            wr = 1'b1;
            if (mem_op) begin
               m2r = 1'b1;
               mc  = o[0];
            end else begin
               aop = {1'b0, o[1:0]};
               acs = o[2];
            end
         end
         default: ;
      endcase
      if (last) begin
         pcwe = 1'b1;
         if (o == 4'b0000 || (br_op && z)) psrc = 2'b01;
         else if (o == 4'b0001)            psrc = 2'b10;
      end
      return {st, ireq, dreq, irwe, pcwe, psrc, m2r, wm, mc, aop, acs, wr, jl};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycles(input int unsigned n, input logic go);
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge clk);
         bus.run        = (i == n - 1) ? go : 1'b0;
         bus.imem_ready = 1'($urandom_range(0, 1));
         bus.dmem_ready = 1'($urandom_range(0, 1));
         bus.zero       = 1'($urandom_range(0, 1));
         #1;
         chk("idle_ctl", 32'(observed()), 32'(model(S_IDLE, bus.op, 1'b0, 1'b0, 1'b0)));
      end
      @(posedge clk);
      #1;
      chk("idle_exit", 32'(bus.state), go ? 32'(S_FETCH) : 32'(S_IDLE));
   endtask

   // One instruction from FETCH; zsel 0/1 forces zero, otherwise random per cycle
   task automatic do_instr(input logic [3:0] o, input int unsigned iw, input int unsigned dw,
                           input int zsel, input logic run_end, input int abort_at);
      logic [2:0] seq[$];
      logic       rdy[$];
      logic       z;
      logic       last;
      logic       mem_op;
      mem_op = (o[3:2] == 2'b01);
      for (int unsigned i = 0; i <= iw; i++) begin
         seq.push_back(S_FETCH);
         rdy.push_back(i == iw);
      end
      seq.push_back(S_DECODE); rdy.push_back(1'b0);
      seq.push_back(S_EXEC);   rdy.push_back(1'b0);
      if (mem_op) begin
         for (int unsigned j = 0; j <= dw; j++) begin
            seq.push_back(S_MEM);
            rdy.push_back(j == dw);
         end
      end
      if (o[3] || (mem_op && !o[1])) begin
         seq.push_back(S_WB);
         rdy.push_back(1'b0);
      end
      for (int k = 0; k < seq.size(); k++) begin
         last = (k == seq.size() - 1);
         @(negedge clk);
         z = (zsel > 1) ? 1'($urandom_range(0, 1)) : 1'(zsel);
         bus.zero = z;
         if (!run_end && seq[k] >= S_EXEC) bus.run = 1'b0;
         else if (last)                    bus.run = run_end;
         else                              bus.run = 1'($urandom_range(0, 1));
         bus.imem_ready = (seq[k] == S_FETCH) ? rdy[k] : 1'($urandom_range(0, 1));
         bus.dmem_ready = (seq[k] == S_MEM)   ? rdy[k] : 1'($urandom_range(0, 1));
         if (seq[k] == S_DECODE) bus.op = o;
         #1;
         chk($sformatf("ctl op=%b cyc=%0d", o, k), 32'(observed()),
             32'(model(seq[k], o, z, rdy[k], last)));
         if (k == abort_at) begin
            #1;
            bus.run = 1'b0;
            rst_n   = 1'b0;
            #1;
            chk("rst_ctl", 32'(observed()), 32'd0);
            chk("rst_retired", 32'(bus.retired), 32'd0);
            #1;
            rst_n       = 1'b1;
            exp_retired = '0;
            return;
         end
      end
      @(posedge clk);
      #1;
      exp_retired = exp_retired + 16'd1;
      chk($sformatf("retired op=%b", o), 32'(bus.retired), 32'(exp_retired));
      chk($sformatf("next_state op=%b", o), 32'(bus.state),
          run_end ? 32'(S_FETCH) : 32'(S_IDLE));
   endtask

   initial begin
      logic [3:0]  rop;
      logic        rrun;
      checks         = 0;
      failures       = 0;
      exp_retired    = '0;
      rst_n          = 1'b0;
      bus.run        = 1'b0;
      bus.op         = 4'b0000;
      bus.zero       = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      #3;
      chk("reset_ctl", 32'(observed()), 32'd0);
      chk("reset_retired", 32'(bus.retired), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      idle_cycles(3, 1'b1);
      do_instr(4'b1000, 0, 0, 1, 1'b1, -1);
      do_instr(4'b0010, 0, 0, 1, 1'b1, -1);
      do_instr(4'b0010, 0, 0, 0, 1'b1, -1);
      do_instr(4'b0011, 1, 0, 0, 1'b1, -1);
      do_instr(4'b0011, 0, 0, 1, 1'b1, -1);
      do_instr(4'b0000, 0, 0, 2, 1'b1, -1);
      do_instr(4'b0001, 2, 0, 2, 1'b1, -1);
      do_instr(4'b0101, 0, 3, 2, 1'b1, -1);
      do_instr(4'b0110, 0, 2, 2, 1'b1, -1);
      do_instr(4'b0100, 0, 0, 2, 1'b1, -1);
      do_instr(4'b0111, 1, 1, 2, 1'b1, -1);
      do_instr(4'b1111, 0, 0, 2, 1'b1, -1);
      do_instr(4'b1100, 0, 0, 2, 1'b0, -1);
      idle_cycles(4, 1'b0);
      idle_cycles(1, 1'b1);

      for (int unsigned n = 0; n < 40; n++) begin
         rop  = 4'($urandom_range(0, 15));
         rrun = ($urandom_range(0, 3) != 0);
         do_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), 2, rrun, -1);
         if (!rrun) idle_cycles($urandom_range(1, 3), 1'b1);
      end

      // load stalled in MEM, reset pulsed asynchronously mid-wait
      do_instr(4'b0101, 1, 5, 2, 1'b1, 6);
      idle_cycles(2, 1'b1);

      n_bulk = 32'h0000_FFFF - 32'(exp_retired);
      bus.run        = 1'b1;
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b0;
      bus.op         = 4'b0010;
      repeat (3 * n_bulk) @(posedge clk);
      #1;
      exp_retired = exp_retired + 16'(n_bulk);
      chk("retired_preload", 32'(bus.retired), 32'(exp_retired));
      chk("preload_state", 32'(bus.state), 32'(S_FETCH));
      do_instr(4'b0111, 0, 2, 2, 1'b1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
